mac_address_matcher: RTL and testbench



---
 rtl/mac_address_matcher.sv | 78 +++++++
 tb/tb_mac_address_matcher.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mac_address_matcher.sv
`default_nettype none
// ============================================================================
//  Module   : mac_address_matcher
//  Brief    : 4-stage word delay line with a sticky byte-aligned 48-bit MAC
//             detector, time-aligned to the MAC's first word on data_out.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_address_matcher (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic [47:0] flagged_mac,
    input  logic [31:0] data_in,
    output logic        match,
    output logic [31:0] data_out
);

    localparam int unsigned C_DATA_W    = 32;
    localparam int unsigned C_MAC_W     = 48;
    localparam int unsigned C_WIN_W     = 3 * C_DATA_W;
    localparam int unsigned C_N_OFFSETS = 4;

    logic [C_DATA_W-1:0]    s1_q, s2_q, s3_q, s4_q;
    logic                   match_q;
    logic                   match_d;
    logic [C_WIN_W-1:0]     w_window;
    logic [C_N_OFFSETS-1:0] w_offset_hit;
    logic                   w_hit;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            s4_q <= '0;
        end else begin
            s1_q <= data_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
            s4_q <= s3_q;
        end
    end

    // Oldest word sits in the top bits so byte offsets count from s3's first byte.
    assign w_window = {s3_q, s2_q, s1_q};

    // Offsets stop at 3 so an occurrence is only judged once its first word is in s3.
    generate
        for (genvar k = 0; k < C_N_OFFSETS; k++) begin : g_offset
            assign w_offset_hit[k] =
                (w_window[C_WIN_W-1-8*k -: C_MAC_W] == flagged_mac);
        end
    endgenerate

    assign w_hit = |w_offset_hit;

    always_comb begin
        match_d = match_q;
        if (clear) begin
            match_d = 1'b0;
        end else if (w_hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match    = match_q;
    assign data_out = s4_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_address_matcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_address_matcher
//  Brief    : Directed self-checking bench for mac_address_matcher.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_address_matcher;

    localparam logic [47:0] C_MAC = 48'h01B2C3D4E5F6;

    logic        clk;
    logic        n_rst;
    logic        clear;
    logic [47:0] flagged_mac;
    logic [31:0] data_in;
    logic        match;
    logic [31:0] data_out;

    int checks;
    int failures;

    mac_address_matcher u_dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (clear),
        .flagged_mac (flagged_mac),
        .data_in     (data_in),
        .match       (match),
        .data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Clear cycle, then feed n words followed by zeros; the first word is
    // expected on data_out after the 4th edge together with match=1.
    task automatic send_seq(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d, input int n);
        logic [31:0] w [4];
        logic [31:0] exp_do;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        clear   = 1'b1;
        data_in = '0;
        tick();
        chk_val({tag, "_clr_match"}, 64'(match), 64'd0);
        clear = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            data_in = (i - 1 < n) ? w[i-1] : 32'h0;
            tick();
            exp_do = (i >= 4 && i - 4 < n) ? w[i-4] : 32'h0;
            chk_val($sformatf("%s_do_e%0d", tag, i), 64'(data_out), 64'(exp_do));
            chk_val($sformatf("%s_match_e%0d", tag, i), 64'(match), (i >= 4) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        n_rst       = 1'b0;
        clear       = 1'b0;
        flagged_mac = C_MAC;
        data_in     = '0;

        // Reset
        tick();
        tick();
        chk_val("rst_do", 64'(data_out), 64'd0);
        chk_val("rst_match", 64'(match), 64'd0);
        n_rst = 1'b1;
        tick();
        tick();
        chk_val("post_rst_do", 64'(data_out), 64'd0);
        chk_val("post_rst_match", 64'(match), 64'd0);

        // MAC at every byte offset
        send_seq("off0", 32'h01B2C3D4, 32'hE5F60000, 32'h0, 32'h0, 2);
        send_seq("off1", 32'h0001B2C3, 32'hD4E5F600, 32'h0, 32'h0, 2);
        send_seq("off2", 32'h000001B2, 32'hC3D4E5F6, 32'h0, 32'h0, 2);
        send_seq("off3", 32'h00000001, 32'hB2C3D4E5, 32'hF6000000, 32'h0, 3);

        // Clear pulse while match=1 without a hit
        clear   = 1'b1;
        data_in = 32'h0;
        tick();
        chk_val("clr_pulse_match", 64'(match), 64'd0);
        chk_val("clr_pulse_do", 64'(data_out), 64'd0);
        clear = 1'b0;
        tick();
        chk_val("clr_hold_match", 64'(match), 64'd0);

        // Clear coincident with the hit edge
        data_in = 32'h01B2C3D4;
        tick();
        data_in = 32'hE5F60000;
        tick();
        data_in = 32'h0;
        tick();
        chk_val("clrhit_pre_match", 64'(match), 64'd0);
        clear = 1'b1;
        tick();
        chk_val("clrhit_match", 64'(match), 64'd0);
        chk_val("clrhit_do", 64'(data_out), 64'h01B2C3D4);
        clear = 1'b0;
        tick();
        chk_val("clrhit_after_match", 64'(match), 64'd0);
        chk_val("clrhit_after_do", 64'(data_out), 64'hE5F60000);
        tick();
        tick();

        // All-ones MAC
        flagged_mac = 48'hFFFFFFFFFFFF;
        send_seq("ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4);

        // All-zero MAC: zero window hits; the clear edge itself wins over it
        flagged_mac = 48'h0;
        clear       = 1'b1;
        data_in     = 32'h0;
        tick();
        chk_val("zero_clr_match", 64'(match), 64'd0);
        clear = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            data_in = (i <= 4) ? 32'hFFFFFFFF : 32'h0;
            tick();
            chk_val($sformatf("zero_match_e%0d", i), 64'(match), 64'd1);
            chk_val($sformatf("zero_do_e%0d", i), 64'(data_out),
                    (i >= 4) ? 64'h00000000FFFFFFFF : 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
